// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen_pkg
// Description : Shared constants, opcode classification and control-flow
//               immediate decode for the instruction-fetch front end.
//               Contents:
//                 c_xlen / c_reset_pc          default datapath width and
//                                              first fetch address
//                 c_opc_branch / c_opc_jal     opcodes recognised by predecode
//                 opc_class_e                  predecode result
//                 f_classify / f_ctrl_imm      predecode helpers
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_gen_pkg;

    localparam int          c_xlen       = 32;
    localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
    localparam logic [6:0]  c_opc_branch = 7'b1100011;
    localparam logic [6:0]  c_opc_jal    = 7'b1101111;

    typedef enum logic [1:0] {
        OPC_CLASS_OTHER  = 2'd0,
        OPC_CLASS_BRANCH = 2'd1,
        OPC_CLASS_JAL    = 2'd2
    } opc_class_e;

    function automatic opc_class_e f_classify(input logic [6:0] opcode);
        opc_class_e cls;
        case (opcode)
            c_opc_branch: cls = OPC_CLASS_BRANCH;
            c_opc_jal:    cls = OPC_CLASS_JAL;
            default:      cls = OPC_CLASS_OTHER;
        endcase
        return cls;
    endfunction

    // Only bits [31:7] carry immediate fields; the opcode is already
    // folded into the class argument.
    function automatic logic [31:0] f_ctrl_imm(input opc_class_e cls,
                                               input logic [31:7] b);
        logic [31:0] imm;
        case (cls)
            OPC_CLASS_BRANCH: imm = {{20{b[31]}}, b[7], b[30:25], b[11:8], 1'b0};
            OPC_CLASS_JAL:    imm = {{12{b[31]}}, b[19:12], b[20], b[30:21], 1'b0};
            default:          imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Two-entry synchronous FIFO with flush, occupancy count, full
//               and empty flags. The head entry is presented directly from
//               storage flops.
//   clk, rst      clock, synchronous active-high reset
//   i_flush       discard all entries (push in the same cycle is ignored)
//   i_push        write i_push_data (accepted when not full or popping)
//   i_pop         remove head entry (ignored when empty)
//   o_head_data   oldest entry
//   o_count       occupancy 0..2
//   o_full        two entries held
//   o_empty       no entries held
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pc_gen_pkg::*;
#(
    parameter int WIDTH = 32 + c_xlen + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A full queue can still take a push when the head leaves this cycle.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = (r_count == 2'd2);
    assign o_empty     = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Instruction-fetch front end. Owns the fetch PC, issues
//               instruction-memory requests under a two-slot credit shared
//               by outstanding requests and queued instructions, predecodes
//               returning words for B-type and JAL, consults the branch
//               predictor combinationally, redirects on predicted-taken and
//               flushes on execute-stage redirects.
//   clk, rst                      clock, synchronous active-high reset
//   o_imem_req/addr, i_imem_gnt   fetch request handshake
//   i_imem_rvalid/rdata           in-order instruction responses
//   o_bp_is_branch/branch_pc/
//   o_bp_offset_pc                predictor lookup for the responding word
//   i_bp_prediction/predicted_pc  same-cycle predictor answer
//   i_redirect/redirect_pc        execute-stage redirect (highest priority)
//   o_if_valid/instr/pc/pred_taken, i_id_ready
//                                 instruction stream toward decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int           N        = c_xlen,
    parameter logic [N-1:0] RESET_PC = N'(c_reset_pc)
) (
    input  logic         clk,
    input  logic         rst,
    output logic         o_imem_req,
    output logic [N-1:0] o_imem_addr,
    input  logic         i_imem_gnt,
    input  logic         i_imem_rvalid,
    input  logic [31:0]  i_imem_rdata,
    output logic         o_bp_is_branch,
    output logic [N-1:0] o_bp_branch_pc,
    output logic [N-1:0] o_bp_offset_pc,
    input  logic         i_bp_prediction,
    input  logic [N-1:0] i_bp_predicted_pc,
    input  logic         i_redirect,
    input  logic [N-1:0] i_redirect_pc,
    output logic         o_if_valid,
    output logic [31:0]  o_if_instr,
    output logic [N-1:0] o_if_pc,
    output logic         o_if_pred_taken,
    input  logic         i_id_ready
);

    localparam int c_q_w = 32 + N + 1;

    logic [N-1:0] r_pc;
    logic [1:0]   r_dsc;

    // Response-PC FIFO: one entry per outstanding request, so its count is
    // the outstanding-request count.
    logic [N-1:0] w_rpc_head;
    logic [1:0]   w_rpc_count;
    logic         w_rpc_full;
    logic         w_rpc_empty;

    logic [c_q_w-1:0] w_q_head;
    logic [1:0]       w_q_count;
    logic             w_q_full;
    logic             w_q_empty;

    logic         w_resp;
    logic         w_resp_live;
    opc_class_e   w_cls;
    logic [31:0]  w_imm;
    logic         w_pred_redirect;
    logic         w_credit;
    logic         w_fire;
    logic [1:0]   w_osd_after;
    logic         w_q_pop;
    logic         w_q_push;

    // ------------------------------------------------------------------
    // Response side and predecode
    // ------------------------------------------------------------------
    assign w_resp      = i_imem_rvalid && !w_rpc_empty;
    assign w_resp_live = w_resp && (r_dsc == 2'd0);
    assign w_cls       = f_classify(i_imem_rdata[6:0]);
    assign w_imm       = f_ctrl_imm(w_cls, i_imem_rdata[31:7]);

    assign o_bp_is_branch  = !rst && w_resp_live && (w_cls != OPC_CLASS_OTHER);
    assign o_bp_branch_pc  = o_bp_is_branch ? w_rpc_head : '0;
    assign o_bp_offset_pc  = o_bp_is_branch ? (w_rpc_head + N'(signed'(w_imm))) : '0;
    assign w_pred_redirect = o_bp_is_branch && i_bp_prediction;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_credit    = ({1'b0, w_rpc_count} + {1'b0, w_q_count}) < 3'd2;
    assign o_imem_req  = !rst && w_credit && !i_redirect && !w_pred_redirect;
    assign o_imem_addr = r_pc;
    assign w_fire      = o_imem_req && i_imem_gnt;

    // Both redirect flavours suppress the request, so only the response
    // can change the outstanding count in those cycles.
    assign w_osd_after = w_rpc_count - {1'b0, w_resp};

    // ------------------------------------------------------------------
    // Instruction queue control
    // ------------------------------------------------------------------
    assign w_q_pop  = !w_q_empty && i_id_ready;
    assign w_q_push = w_resp_live && !i_redirect && (!w_q_full || w_q_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_dsc <= 2'd0;
        end else if (i_redirect) begin
            r_pc  <= i_redirect_pc;
            r_dsc <= w_osd_after;
        end else if (w_pred_redirect) begin
            r_pc  <= i_bp_predicted_pc;
            r_dsc <= w_osd_after;
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + N'(4);
            end
            if (w_resp && (r_dsc != 2'd0)) begin
                r_dsc <= r_dsc - 2'd1;
            end
        end
    end

    fetch_queue #(
        .WIDTH (N)
    ) u_rpc_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (1'b0),
        .i_push      (w_fire && !w_rpc_full),
        .i_push_data (r_pc),
        .i_pop       (w_resp),
        .o_head_data (w_rpc_head),
        .o_count     (w_rpc_count),
        .o_full      (w_rpc_full),
        .o_empty     (w_rpc_empty)
    );

    fetch_queue #(
        .WIDTH (c_q_w)
    ) u_instr_q (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_redirect),
        .i_push      (w_q_push),
        .i_push_data ({i_imem_rdata, w_rpc_head, w_pred_redirect}),
        .i_pop       (w_q_pop),
        .o_head_data (w_q_head),
        .o_count     (w_q_count),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

    assign o_if_valid                               = !w_q_empty;
    assign {o_if_instr, o_if_pc, o_if_pred_taken}   = w_q_head;

endmodule
`default_nettype wire
